// File: rtl/circle_draw.sv
// Circle outline sequencer: steps a midpoint distance generator one iteration at
// a time and expands each (xa, ya) step into four quadrant-symmetric pixels.

module circle #(
  parameter int CORDW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rst,
  input  logic             start,
  input  logic             oe,
  input  logic [CORDW-1:0] r0,
  output logic [CORDW-1:0] xa,
  output logic [CORDW-1:0] ya,
  output logic             valid,
  output logic             done
);
  localparam int EW = CORDW + 2;
  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_INIT   = 3'd1;
  localparam logic [2:0] C_DRAW   = 3'd2;
  localparam logic [2:0] C_CHK    = 3'd3;
  localparam logic [2:0] C_CALC_Y = 3'd4;
  localparam logic [2:0] C_CALC_X = 3'd5;
  localparam logic signed [EW-1:0] E_TWO   = EW'(2);
  localparam logic signed [EW-1:0] E_THREE = EW'(3);
  localparam logic [CORDW-1:0]     ONE     = CORDW'(1);

  logic [2:0]              state_q, state_d;
  logic signed [CORDW-1:0] xa_q, xa_d, ya_q, ya_d;
  logic signed [EW-1:0]    err_q, err_d, errt_q, errt_d;
  logic signed [EW-1:0]    xa_e, ya_e, r_e;
  logic                    valid_q, valid_d, done_q, done_d;

  assign xa_e  = {{2{xa_q[CORDW-1]}}, xa_q};
  assign ya_e  = {{2{ya_q[CORDW-1]}}, ya_q};
  assign r_e   = {{2{r0[CORDW-1]}}, r0};
  assign xa    = xa_q;
  assign ya    = ya_q;
  assign valid = valid_q;
  assign done  = done_q;

  // Error term is kept two bits wider than the coordinates so 2*r never overflows.
  always_comb begin
    state_d = state_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    err_d   = err_q;
    errt_d  = errt_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      C_IDLE: if (start) begin
        xa_d    = -r0;
        ya_d    = '0;
        err_d   = E_TWO - r_e - r_e;
        state_d = C_INIT;
      end
      C_INIT: begin
        valid_d = 1'b1;
        state_d = C_DRAW;
      end
      C_DRAW: if (oe) begin
        valid_d = 1'b0;
        state_d = C_CHK;
      end
      C_CHK: begin
        if (xa_q == '0) begin
          done_d  = 1'b1;
          state_d = C_IDLE;
        end else begin
          errt_d  = err_q;
          state_d = C_CALC_Y;
        end
      end
      C_CALC_Y: begin
        if (errt_q <= ya_e) begin
          ya_d  = ya_q + ONE;
          err_d = err_q + ya_e + ya_e + E_THREE;
        end
        state_d = C_CALC_X;
      end
      C_CALC_X: begin
        if (errt_q > xa_e || err_q > ya_e) begin
          xa_d  = xa_q + ONE;
          err_d = err_q + xa_e + xa_e + E_THREE;
        end
        valid_d = 1'b1;
        state_d = C_DRAW;
      end
      default: state_d = C_IDLE;
    endcase
    if (rst) begin
      state_d = C_IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= C_IDLE;
      xa_q    <= '0;
      ya_q    <= '0;
      err_q   <= '0;
      errt_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      err_q   <= err_d;
      errt_q  <= errt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
endmodule

// valid/oe handshake: a point is transferred on any rising edge where valid && oe;
// while valid && !oe, x, y and valid hold unchanged.
module circle_draw #(
  parameter int CORDW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             oe,
  input  logic [CORDW-1:0] x0,
  input  logic [CORDW-1:0] y0,
  input  logic [CORDW-1:0] r0,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic             busy,
  output logic             valid,
  output logic             done
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_PLOT = 3'd3;
  localparam logic [2:0] S_ADV  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CORDW-1:0] x0_q, x0_d, y0_q, y0_d, r_q, r_d, xs_q, xs_d, ys_q, ys_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             abort_cancel, core_rst, core_start, core_oe, core_valid, core_done;
  logic [CORDW-1:0] core_xa, core_ya;

  assign abort_cancel = abort && (state_q != S_IDLE);
  assign core_rst     = !rst_n || abort_cancel;
  assign core_start   = (state_q == S_INIT);
  assign core_oe      = (state_q == S_ADV);
  assign busy         = busy_q;
  assign done         = done_q;
  assign valid        = (state_q == S_PLOT);

  circle #(.CORDW(CORDW)) u_circle (
    .clk   (clk),
    .rst_n (rst_n),
    .rst   (core_rst),
    .start (core_start),
    .oe    (core_oe),
    .r0    (r_q),
    .xa    (core_xa),
    .ya    (core_ya),
    .valid (core_valid),
    .done  (core_done)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    r_d     = r_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          if (!r0[CORDW-1]) begin
            x0_d    = x0;
            y0_d    = y0;
            r_d     = r0;
            busy_d  = 1'b1;
            state_d = S_INIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_INIT: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          state_d = S_FIN;
        end else if (core_valid) begin
          xs_d    = core_xa;
          ys_d    = core_ya;
          idx_d   = 2'd0;
          state_d = S_PLOT;
        end
      end
      S_PLOT: if (oe) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_ADV;
      end
      S_ADV: state_d = S_WAIT;
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_cancel) begin
      busy_d  = 1'b0;
      done_d  = 1'b0;
      state_d = S_IDLE;
    end
  end

  // xs is always <= 0 and ys >= 0, giving one point per quadrant.
  always_comb begin
    x = '0;
    y = '0;
    if (state_q == S_PLOT) begin
      case (idx_q)
        2'd0: begin x = x0_q - xs_q; y = y0_q + ys_q; end
        2'd1: begin x = x0_q - ys_q; y = y0_q - xs_q; end
        2'd2: begin x = x0_q + xs_q; y = y0_q - ys_q; end
        default: begin x = x0_q + ys_q; y = y0_q + xs_q; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      x0_q    <= '0;
      y0_q    <= '0;
      r_q     <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      r_q     <= r_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_circle_draw.sv
// Bench for circle_draw: table of circles plus random circles against a
// plain-integer midpoint model, and hand sequences for abort and reset.

module tb_circle_draw;
  localparam int CORDW = 16;
  localparam int W     = 2 * CORDW;

  typedef struct {
    int cx;
    int cy;
    int r;
    int oe_pct;
    int exp_n;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             oe = 1'b0;
  logic [CORDW-1:0] x0 = '0;
  logic [CORDW-1:0] y0 = '0;
  logic [CORDW-1:0] r0 = '0;
  logic [CORDW-1:0] x, y;
  logic             busy, valid, done;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  circle_draw #(.CORDW(CORDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .oe    (oe),
    .x0    (x0),
    .y0    (y0),
    .r0    (r0),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .valid (valid),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic void push_pt(input int px, input int py);
    logic [CORDW-1:0] tx, ty;
    tx = px[CORDW-1:0];
    ty = py[CORDW-1:0];
    exp_q.push_back({tx, ty});
  endfunction

  // Midpoint circle walk in integers; each step yields four rotated points.
  function automatic void model(input int cx, input int cy, input int r);
    int xa, ya, err, e2;
    exp_q.delete();
    if (r < 0) return;
    xa  = -r;
    ya  = 0;
    err = 2 - 2 * r;
    forever begin
      push_pt(cx - xa, cy + ya);
      push_pt(cx - ya, cy - xa);
      push_pt(cx + xa, cy - ya);
      push_pt(cx + ya, cy + xa);
      if (xa == 0) break;
      e2 = err;
      if (e2 <= ya) begin ya++; err += 2 * ya + 1; end
      if (e2 > xa || err > ya) begin xa++; err += 2 * xa + 1; end
    end
  endfunction

  // flags: [0] check latency/spacing, [1] pulse start mid-draw, [2] abort with start
  task automatic run_draw(input int cx, input int cy, input int r, input int oe_pct,
                          input int abort_at, input logic [2:0] flags,
                          output int got, output logic [W-1:0] first_xy);
    int acc, last_i0, seen;
    bit fin, prev_stall;
    logic [W-1:0] prev_xy, want;
    model(cx, cy, r);
    acc = 0; last_i0 = -1; fin = 0; prev_stall = 0; prev_xy = '0; first_xy = '0;
    @(negedge clk);
    x0 = cx[CORDW-1:0];
    y0 = cy[CORDW-1:0];
    r0 = r[CORDW-1:0];
    start = 1'b1;
    abort = flags[2];
    oe = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (valid || done) check("valid_done_excl", W'(valid & done), '0);
      if (prev_stall) begin
        check("hold_valid", W'(valid), W'(1));
        check("hold_xy", {x, y}, prev_xy);
      end
      if (valid) check("busy_in_plot", W'(busy), W'(1));
      oe = ($urandom_range(0, 99) < oe_pct);
      if (flags[1] && cyc == 20) begin
        start = 1'b1; x0 = 16'd5; y0 = 16'd5; r0 = 16'd2;
      end
      if (abort_at > 0 && valid && acc == abort_at - 1) begin
        abort = 1'b1; oe = 1'b1;
      end
      if (valid && oe) begin
        if (flags[0] && acc == 0) check("first_latency", W'(cyc), W'(3));
        if (flags[0] && acc % 4 == 0 && last_i0 >= 0) check("idx0_spacing", W'(cyc - last_i0), W'(9));
        if (acc % 4 == 0) last_i0 = cyc;
        if (acc == 0) first_xy = {x, y};
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_point: got %h want none", {x, y});
        end else begin
          want = exp_q.pop_front();
          check("point", {x, y}, want);
        end
        acc++;
      end
      prev_stall = valid && !oe;
      prev_xy = {x, y};
      if (abort) begin
        @(negedge clk);
        abort = 1'b0; oe = 1'b0;
        check("abort_valid", W'(valid), '0);
        check("abort_busy", W'(busy), '0);
        check("abort_done", W'(done), '0);
        seen = 0;
        repeat (6) begin
          @(negedge clk);
          seen = seen | int'(done) | int'(valid) | int'(busy);
        end
        check("abort_quiet", W'(seen), '0);
        exp_q.delete();
        fin = 1;
      end else if (done) begin
        if (r < 0) check("neg_done_lat", W'(cyc), '0);
        check("done_busy", W'(busy), '0);
        check("points_left", W'(exp_q.size()), '0);
        @(negedge clk);
        check("done_one_pulse", W'(done), '0);
        check("idle_busy", W'(busy), '0);
        fin = 1;
      end
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL draw_timeout: got no done want done within 3000 cycles");
    end
    got = acc;
    oe = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int got, fx, n, seen, rcx, rcy, rr, pct;
    logic [W-1:0] fxy;
    logic [CORDW-1:0] ex, ey;

    vecs[0] = '{10, 20, 0, 100, 4};
    vecs[1] = '{0, 0, 1, 100, 8};
    vecs[2] = '{100, 50, 5, 100, 32};
    vecs[3] = '{100, 50, 5, 50, 32};
    vecs[4] = '{-30, 7, 3, 100, 20};
    vecs[5] = '{32765, -32767, 5, 70, 32};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_x", W'(x), '0);
    check("rst_y", W'(y), '0);
    check("rst_valid", W'(valid), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    rst_n = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort", W'({valid, busy, done}), '0);

    for (int i = 0; i < 6; i++) begin
      run_draw(vecs[i].cx, vecs[i].cy, vecs[i].r, vecs[i].oe_pct, 0, 3'b000, got, fxy);
      check("count", W'(got), W'(vecs[i].exp_n));
      fx = vecs[i].cx + vecs[i].r; ex = fx[CORDW-1:0];
      fx = vecs[i].cy;             ey = fx[CORDW-1:0];
      check("first_pt", fxy, {ex, ey});
    end

    run_draw(7, -3, 5, 100, 0, 3'b011, got, fxy);
    check("timing_count", W'(got), W'(32));

    run_draw(40, 40, 5, 100, 6, 3'b000, got, fxy);
    check("abort_count", W'(got), W'(6));
    run_draw(-5, 9, 3, 100, 0, 3'b100, got, fxy);
    check("after_abort_count", W'(got), W'(20));

    for (int i = 0; i < 6; i++) begin
      rcx = int'($urandom_range(0, 400)) - 200;
      rcy = int'($urandom_range(0, 400)) - 200;
      rr  = int'($urandom_range(0, 20));
      pct = int'($urandom_range(30, 100));
      model(rcx, rcy, rr);
      n = exp_q.size();
      run_draw(rcx, rcy, rr, pct, 0, 3'b000, got, fxy);
      check("rand_count", W'(got), W'(n));
    end

    @(negedge clk);
    x0 = 16'd20; y0 = 16'd30; r0 = 16'd5; start = 1'b1; oe = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_valid", W'(valid), W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_xy", {x, y}, '0);
    check("rst_async_ctl", W'({valid, busy, done}), '0);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | int'(done) | int'(valid) | int'(busy);
    end
    check("post_reset_quiet", W'(seen), '0);
    run_draw(0, 0, -4, 100, 0, 3'b000, got, fxy);
    check("neg_radius_count", W'(got), '0);
    model(3, 3, 4);
    n = exp_q.size();
    run_draw(3, 3, 4, 100, 0, 3'b000, got, fxy);
    check("recover_count", W'(got), W'(n));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/circle_draw.md
Name: circle_draw

Overview:
- Sequencer that turns a (centre, radius) request into a stream of outline pixel coordinates for the framebuffer write path.
- Instantiates the existing `circle` distance generator internally and steps it one iteration at a time.
- Expands each (xa, ya) distance pair into four quadrant-symmetric points.
- Presents points one per cycle on a valid/oe handshake to the downstream pixel writer.

Parameters:
CORDW, 16, signed coordinate width of centre, radius and output coordinates.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  begin drawing; sampled only in IDLE
abort  in  1  synchronous cancel of drawing in progress
oe  in  1  downstream accepts current point when valid && oe
x0  in  CORDW  signed centre x, sampled with start
y0  in  CORDW  signed centre y, sampled with start
r0  in  CORDW  signed radius, sampled with start
x  out  CORDW  signed pixel x
y  out  CORDW  signed pixel y
busy  out  1  drawing in progress
valid  out  1  x,y hold a point to draw
done  out  1  drawing complete, one-cycle pulse

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; busy, valid, done = 0; x, y = 0.
  - Internal core is held in reset via its rst input driven by (!rst_n | abort_cancel).
- States:
  - IDLE:
    - done <= 0.
    - On start with r0 >= 0: latch x0, y0, r0; busy <= 1; -> INIT.
    - On start with r0 < 0: no pixels; pulse done next cycle; busy stays 0.
    - start while busy is ignored.
  - INIT: assert core start for exactly one cycle; -> WAIT_V.
  - WAIT_V:
    - If core done: -> FIN.
    - Else if core valid: latch core xa, ya into step registers; idx <= 0; -> PLOT.
    - Core oe is held 0 throughout.
  - PLOT:
    - valid=1 and x,y driven from idx (xa <= 0, ya >= 0):
      - idx0 = (x0-xa, y0+ya)
      - idx1 = (x0-ya, y0-xa)
      - idx2 = (x0+xa, y0-ya)
      - idx3 = (x0+ya, y0+xa)
    - x, y, valid stay stable while oe=0.
    - On oe: idx++; after idx3 is accepted -> ADV.
  - ADV: valid=0; core oe=1 for exactly one cycle; -> WAIT_V.
  - FIN: busy <= 0; done <= 1 for one cycle; -> IDLE.
- Latency:
  - First point valid 3 cycles after the edge that samples start.
  - With oe held high, consecutive idx0 points are 9 cycles apart: 4 plot + ADV + 3 core calc + latch.
- Arithmetic:
  - Sums and differences are CORDW-bit two's complement and wrap on overflow.
  - No clipping; downstream handles off-screen points.
- Duplicates:
  - Axis points (xa=0 or ya=0) emit coincident coordinates; these are not suppressed.
  - r0=0 emits 4 points all at the centre.
- Abort:
  - In any non-IDLE state: valid <= 0, busy <= 0, -> IDLE next edge, core reset for one cycle.
  - No done pulse.
  - Abort in IDLE has no effect.
  - Abort and start together in IDLE: start wins.
- Reset mid-draw: immediate return to IDLE with all outputs 0; no done pulse after reset releases.
- done and valid are never high in the same cycle.

Test Plan:
- r0=0, x0=10, y0=20, oe=1 -> exactly 4 points (10,20); done pulses once, then busy=0.
- r0=1, centre (0,0), oe=1 -> first step points (1,0),(0,1),(-1,0),(0,-1); point set matches software midpoint model; single done pulse.
- r0=5, centre (100,50), oe random 50% -> point multiset identical to oe=1 run; x,y,valid never change while valid && !oe.
- r0=5, oe=1 -> first valid 3 cycles after start; idx0 points spaced 9 cycles; start pulsed mid-draw is ignored.
- Abort asserted on 6th accepted point -> valid low next cycle, busy=0, no done; a new start with r0=3 then draws a correct full circle.
- rst_n pulled low mid-PLOT (async, between edges) -> outputs 0 immediately; r0=-4 start after release -> zero points, done pulse, busy stays 0.
